// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register file's two read ports and single write
// port between two requesters. Each accepted request passes through one
// registered issue stage, and the requester gets a registered completion pulse.
module regfile_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic            i_we0,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_rs1_0,
    input  logic [AW-1:0]   i_rs2_0,
    input  logic [AW-1:0]   i_rd_0,
    input  logic [AW-1:0]   i_rs1_1,
    input  logic [AW-1:0]   i_rs2_1,
    input  logic [AW-1:0]   i_rd_1,
    input  logic [XLEN-1:0] i_wdata0,
    input  logic [XLEN-1:0] i_wdata1,
    input  logic            i_lock1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    output logic            o_rvalid0,
    output logic            o_rvalid1,
    output logic [XLEN-1:0] o_rdata1_0,
    output logic [XLEN-1:0] o_rdata2_0,
    output logic [XLEN-1:0] o_rdata1_1,
    output logic [XLEN-1:0] o_rdata2_1,
    output logic [AW-1:0]   o_rf_rs1,
    output logic [AW-1:0]   o_rf_rs2,
    output logic [AW-1:0]   o_rf_rd,
    output logic [XLEN-1:0] o_rf_writedata,
    output logic            o_rf_regwrite,
    input  logic [XLEN-1:0] i_rf_ReadData1,
    input  logic [XLEN-1:0] i_rf_ReadData2
);

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_accept;
    logic            w_selWe;
    logic [AW-1:0]   w_selRs1;
    logic [AW-1:0]   w_selRs2;
    logic [AW-1:0]   w_selRd;
    logic [XLEN-1:0] w_selWdata;

    logic            r_prio;
    logic            r_issV;
    logic            r_issId;
    logic            r_issWe;
    logic [AW-1:0]   r_issRs1;
    logic [AW-1:0]   r_issRs2;
    logic [AW-1:0]   r_issRd;
    logic [XLEN-1:0] r_issWdata;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic [XLEN-1:0] r_rdata1_0;
    logic [XLEN-1:0] r_rdata2_0;
    logic [XLEN-1:0] r_rdata1_1;
    logic [XLEN-1:0] r_rdata2_1;

    // Grant decision: a lone requester wins; on conflict lock1 forces requester 1, else the round-robin pointer decides
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst_n) begin
            if (i_req0 && i_req1) begin
                if (i_lock1 || r_prio) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1;
            end
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_selWe    = w_gnt1 ? i_we1    : i_we0;
    assign w_selRs1   = w_gnt1 ? i_rs1_1  : i_rs1_0;
    assign w_selRs2   = w_gnt1 ? i_rs2_1  : i_rs2_0;
    assign w_selRd    = w_gnt1 ? i_rd_1   : i_rd_0;
    assign w_selWdata = w_gnt1 ? i_wdata1 : i_wdata0;

    // Round-robin pointer favours the requester that was not granted last, even while lock1 is high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= 1'b0;
        end else if (w_gnt0) begin
            r_prio <= 1'b1;
        end else if (w_gnt1) begin
            r_prio <= 1'b0;
        end
    end

    // Issue stage: fields load only on accept, so the register-file ports hold their last values when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issV     <= 1'b0;
            r_issId    <= 1'b0;
            r_issWe    <= 1'b0;
            r_issRs1   <= '0;
            r_issRs2   <= '0;
            r_issRd    <= '0;
            r_issWdata <= '0;
        end else begin
            r_issV <= w_accept;
            if (w_accept) begin
                r_issId    <= w_gnt1;
                r_issWe    <= w_selWe;
                r_issRs1   <= w_selRs1;
                r_issRs2   <= w_selRs2;
                r_issRd    <= w_selRd;
                r_issWdata <= w_selWdata;
            end
        end
    end

    // Response stage: completes the issued request, capturing read data or zero for writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata1_0 <= '0;
            r_rdata2_0 <= '0;
            r_rdata1_1 <= '0;
            r_rdata2_1 <= '0;
        end else begin
            r_rvalid0 <= r_issV & ~r_issId;
            r_rvalid1 <= r_issV & r_issId;
            if (r_issV && !r_issId) begin
                r_rdata1_0 <= r_issWe ? '0 : i_rf_ReadData1;
                r_rdata2_0 <= r_issWe ? '0 : i_rf_ReadData2;
            end
            if (r_issV && r_issId) begin
                r_rdata1_1 <= r_issWe ? '0 : i_rf_ReadData1;
                r_rdata2_1 <= r_issWe ? '0 : i_rf_ReadData2;
            end
        end
    end

    assign o_gnt0         = w_gnt0;
    assign o_gnt1         = w_gnt1;
    assign o_rvalid0      = r_rvalid0;
    assign o_rvalid1      = r_rvalid1;
    assign o_rdata1_0     = r_rdata1_0;
    assign o_rdata2_0     = r_rdata2_0;
    assign o_rdata1_1     = r_rdata1_1;
    assign o_rdata2_1     = r_rdata2_1;
    assign o_rf_rs1       = r_issRs1;
    assign o_rf_rs2       = r_issRs2;
    assign o_rf_rd        = r_issRd;
    assign o_rf_writedata = r_issWdata;
    assign o_rf_regwrite  = r_issV & r_issWe & (r_issRd != '0);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration and register contents.
module tb_regfile_arbiter;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wdata;
    } reqT;

    typedef struct packed {
        logic            id;
        logic [31:0]     due;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
    } respT;

    logic            clk;
    logic            rstN;
    logic            req0, req1, we0, we1, lock1;
    logic [AW-1:0]   rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    logic [XLEN-1:0] wdata0, wdata1;
    logic            gnt0, gnt1, rvalid0, rvalid1;
    logic [XLEN-1:0] rdata1_0, rdata2_0, rdata1_1, rdata2_1;
    logic [AW-1:0]   rfRs1, rfRs2, rfRd;
    logic [XLEN-1:0] rfWritedata;
    logic            rfRegwrite;
    logic [XLEN-1:0] rfReadData1, rfReadData2;

    // Register file seen by the DUT; it only changes through the DUT's write port
    logic [XLEN-1:0] envMem [32];

    // Reference model state
    reqT             pend [2];
    bit              pendV [2];
    int              prioModel;
    logic [XLEN-1:0] modelMem [32];
    logic [XLEN-1:0] expD1 [2];
    logic [XLEN-1:0] expD2 [2];
    respT            respQ [$];
    int              cycleNo;
    bit              expRegwrite;
    int              lastWrRd;
    logic [XLEN-1:0] lastWrOld;

    int checks;
    int errors;

    regfile_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_req0(req0),
        .i_req1(req1),
        .i_we0(we0),
        .i_we1(we1),
        .i_rs1_0(rs1_0),
        .i_rs2_0(rs2_0),
        .i_rd_0(rd_0),
        .i_rs1_1(rs1_1),
        .i_rs2_1(rs2_1),
        .i_rd_1(rd_1),
        .i_wdata0(wdata0),
        .i_wdata1(wdata1),
        .i_lock1(lock1),
        .o_gnt0(gnt0),
        .o_gnt1(gnt1),
        .o_rvalid0(rvalid0),
        .o_rvalid1(rvalid1),
        .o_rdata1_0(rdata1_0),
        .o_rdata2_0(rdata2_0),
        .o_rdata1_1(rdata1_1),
        .o_rdata2_1(rdata2_1),
        .o_rf_rs1(rfRs1),
        .o_rf_rs2(rfRs2),
        .o_rf_rd(rfRd),
        .o_rf_writedata(rfWritedata),
        .o_rf_regwrite(rfRegwrite),
        .i_rf_ReadData1(rfReadData1),
        .i_rf_ReadData2(rfReadData2)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file write port and combinational read ports
    always @(posedge clk) begin
        if (rfRegwrite) envMem[rfRd] <= rfWritedata;
    end
    assign rfReadData1 = envMem[rfRs1];
    assign rfReadData2 = envMem[rfRs2];

    // Counts one comparison and reports it when the observed value differs
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic reqT makeReq(input logic we, input int rs1, input int rs2, input int rd, input logic [XLEN-1:0] wd);
        reqT r;
        r.we    = we;
        r.rs1   = AW'(rs1);
        r.rs2   = AW'(rs2);
        r.rd    = AW'(rd);
        r.wdata = wd;
        return r;
    endfunction

    function automatic reqT randReq();
        return makeReq(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), {$urandom, $urandom});
    endfunction

    // Drives the DUT request ports from the pending (held until granted) requests
    task automatic driveInputs();
        req0 = pendV[0]; we0 = pend[0].we; rs1_0 = pend[0].rs1; rs2_0 = pend[0].rs2;
        rd_0 = pend[0].rd; wdata0 = pend[0].wdata;
        req1 = pendV[1]; we1 = pend[1].we; rs1_1 = pend[1].rs1; rs2_1 = pend[1].rs2;
        rd_1 = pend[1].rd; wdata1 = pend[1].wdata;
    endtask

    // Checks completion pulses, response data and the write enable after an edge
    task automatic verifyCycle();
        bit   v [2];
        respT rsp;
        v[0] = 1'b0;
        v[1] = 1'b0;
        while (respQ.size() > 0 && int'(respQ[0].due) == cycleNo) begin
            rsp = respQ.pop_front();
            v[rsp.id] = 1'b1;
            expD1[rsp.id] = rsp.d1;
            expD2[rsp.id] = rsp.d2;
        end
        checkOutput("rvalid0", rvalid0, v[0]);
        checkOutput("rvalid1", rvalid1, v[1]);
        checkOutput("rdata1_0", rdata1_0, expD1[0]);
        checkOutput("rdata2_0", rdata2_0, expD2[0]);
        checkOutput("rdata1_1", rdata1_1, expD1[1]);
        checkOutput("rdata2_1", rdata2_1, expD2[1]);
        checkOutput("rf_regwrite", rfRegwrite, expRegwrite);
    endtask

    // One clock of traffic: predict grants, let the edge happen, update the model, check results
    task automatic applyStimulus(input bit lock);
        bit   g0, g1;
        int   w;
        reqT  r;
        respT rsp;
        lock1 = lock;
        driveInputs();
        #1;
        g0 = pendV[0] && (!pendV[1] || (!lock && prioModel == 0));
        g1 = pendV[1] && (!pendV[0] || lock || prioModel == 1);
        checkOutput("gnt0", gnt0, g0);
        checkOutput("gnt1", gnt1, g1);
        @(posedge clk);
        expRegwrite = 1'b0;
        if (g0 || g1) begin
            w = g1 ? 1 : 0;
            r = pend[w];
            pendV[w] = 1'b0;
            prioModel = 1 - w;
            rsp.id  = w[0];
            rsp.due = 32'(cycleNo + 2);
            if (r.we) begin
                rsp.d1 = '0;
                rsp.d2 = '0;
                if (r.rd != 0) begin
                    lastWrRd  = int'(r.rd);
                    lastWrOld = modelMem[r.rd];
                    modelMem[r.rd] = r.wdata;
                    expRegwrite = 1'b1;
                end
            end else begin
                rsp.d1 = modelMem[r.rs1];
                rsp.d2 = modelMem[r.rs2];
            end
            respQ.push_back(rsp);
        end
        cycleNo++;
        @(negedge clk);
        verifyCycle();
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_gnt0"}, gnt0, 0);
        checkOutput({phase, "_gnt1"}, gnt1, 0);
        checkOutput({phase, "_rvalid0"}, rvalid0, 0);
        checkOutput({phase, "_rvalid1"}, rvalid1, 0);
        checkOutput({phase, "_regwrite"}, rfRegwrite, 0);
        checkOutput({phase, "_rdata"}, rdata1_0 | rdata2_0 | rdata1_1 | rdata2_1, 0);
        checkOutput({phase, "_rfaddr"}, {rfRs1, rfRs2, rfRd}, 0);
        checkOutput({phase, "_rfwdata"}, rfWritedata, 0);
    endtask

    // Clears the model to its post-reset state, undoing a write whose commit edge never came
    task automatic modelReset();
        if (expRegwrite) modelMem[lastWrRd] = lastWrOld;
        expRegwrite = 1'b0;
        prioModel = 0;
        respQ.delete();
        for (int i = 0; i < 2; i++) begin
            expD1[i] = '0;
            expD2[i] = '0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycleNo = 0;
        prioModel = 0;
        expRegwrite = 1'b0;
        lastWrRd = 0;
        lastWrOld = '0;
        for (int i = 0; i < 32; i++) begin
            envMem[i] = '0;
            modelMem[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            pendV[i] = 1'b0;
            pend[i] = '0;
            expD1[i] = '0;
            expD2[i] = '0;
        end
        rstN = 1'b0;
        lock1 = 1'b0;
        driveInputs();

        // Power-on reset with a request pending: no grant may appear
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("por");
        req0 = 1'b0;
        rstN = 1'b1;

        // Write x5 then read it back on the next cycle
        pend[0] = makeReq(1'b1, 0, 0, 5, 64'hDEADBEEF_00000001); pendV[0] = 1'b1;
        applyStimulus(1'b0);
        pend[0] = makeReq(1'b0, 5, 0, 0, '0); pendV[0] = 1'b1;
        applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b0);

        // Write to x0 is dropped but still completes; x0 reads as zero
        pend[1] = makeReq(1'b1, 0, 0, 0, '1); pendV[1] = 1'b1;
        applyStimulus(1'b0);
        pend[1] = makeReq(1'b0, 0, 5, 0, '0); pendV[1] = 1'b1;
        applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b0);

        // Preload x1..x8, then eight back-to-back reads
        for (int i = 1; i <= 8; i++) begin
            pend[0] = makeReq(1'b1, 0, 0, i, 64'(i * 'h11)); pendV[0] = 1'b1;
            applyStimulus(1'b0);
        end
        for (int i = 1; i <= 8; i++) begin
            pend[0] = makeReq(1'b0, i, 9 - i, 0, '0); pendV[0] = 1'b1;
            applyStimulus(1'b0);
        end
        repeat (2) applyStimulus(1'b0);

        // Contention: both held for 4 cycles, then lock1 for 3 cycles, then released
        for (int c = 0; c < 8; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pendV[n]) begin
                    pend[n] = makeReq(1'b0, $urandom_range(1, 8), $urandom_range(1, 8), 0, '0);
                    pendV[n] = 1'b1;
                end
            end
            applyStimulus((c >= 4 && c < 7) ? 1'b1 : 1'b0);
        end
        pendV[0] = 1'b0;
        pendV[1] = 1'b0;
        repeat (3) applyStimulus(1'b0);

        // Reset during the issue cycle of a write: write is lost, no completion
        pend[0] = makeReq(1'b1, 0, 0, 9, 64'hCAFE_F00D_1234_5678); pendV[0] = 1'b1;
        applyStimulus(1'b0);
        pend[1] = makeReq(1'b0, 9, 3, 0, '0); pendV[1] = 1'b1;
        driveInputs();
        rstN = 1'b0;
        #1;
        checkAllZero("midrst");
        modelReset();
        @(posedge clk);
        cycleNo++;
        @(negedge clk);
        checkAllZero("inrst");
        rstN = 1'b1;
        pend[0] = makeReq(1'b0, 9, 5, 0, '0); pendV[0] = 1'b1;
        repeat (4) applyStimulus(1'b0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pendV[n] && $urandom_range(0, 9) < 6) begin
                    pend[n] = randReq();
                    pendV[n] = 1'b1;
                end
            end
            applyStimulus($urandom_range(0, 3) == 0 ? 1'b1 : 1'b0);
        end
        pendV[0] = 1'b0;
        pendV[1] = 1'b0;
        repeat (3) applyStimulus(1'b0);

        checkOutput("respQ_empty", 64'(respQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer for the 64-bit, 32-entry register file. It shares the file's two read ports and single write port between requester 0 (core writeback/operand fetch) and requester 1 (debug/load unit). Accepted requests pass through one registered issue stage that drives the register file, and each requester receives a registered completion response. The block sits between the core control path and `registerFile`, replacing the hard-tied `writedata`/`regwrite` nets.

## Interface
- `XLEN`, 64, data width
- `AW`, 5, register address width (32 registers)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  request valid; held with its fields stable until granted
- `we0`, `we1`  in  1  1 = write `wdataN` to `rdN`; 0 = read `rs1_N`/`rs2_N`
- `rs1_0`, `rs2_0`, `rd_0`, `rs1_1`, `rs2_1`, `rd_1`  in  AW  register addresses
- `wdata0`, `wdata1`  in  XLEN  write data
- `lock1`  in  1  while high, requester 1 wins every conflict
- `gnt0`, `gnt1`  out  1  combinational accept; transfer occurs on an edge where `reqN & gntN`
- `rvalid0`, `rvalid1`  out  1  one-cycle completion pulse
- `rdata1_0`, `rdata2_0`, `rdata1_1`, `rdata2_1`  out  XLEN  read results, valid with `rvalidN`
- `rf_rs1`, `rf_rs2`, `rf_rd`  out  AW  register-file addresses
- `rf_writedata`  out  XLEN  register-file write data
- `rf_regwrite`  out  1  register-file write enable
- `rf_ReadData1`, `rf_ReadData2`  in  XLEN  combinational register-file read data

## Operation
- Round-robin pointer `prio` (reset 0) names the favoured requester.
- Only one requester active: it is granted.
- Both active: `lock1`=1 grants requester 1; otherwise `prio` wins.
- After any grant to N, `prio` becomes the other requester. `lock1` does not freeze `prio`.
- `gnt` is at most one-hot and is never asserted toward an idle requester.
- Issue register (`iss_v`, `iss_id`, `iss_we`, addresses, data) loads the accepted request every edge. `iss_v`=0 when nothing is accepted.
- While `iss_v`=1, `rf_*` addresses and data come from the issue register. While `iss_v`=0, they hold their last values.
- `rf_regwrite` = `iss_v & iss_we & (iss_rd != 0)`. Writes to x0 are dropped but still complete.
- Response register: on the edge that ends an issue cycle, `rvalid[iss_id]` is set for one cycle.
  - Reads capture `rf_ReadData1`/`rf_ReadData2` into that requester's `rdata1`/`rdata2`.
  - Writes load 0 into both.
  - The other requester's `rdata` holds its value.
- Full throughput: one accept per cycle. There are no stalls and no backpressure on responses.
- A read issued the cycle after a write to the same register sees the new value, because the write commits at the edge ending its issue cycle.

## Timing
- Accept at edge E0. Register-file access occurs during cycle E0→E1, and a write commits at E1. `rvalidN` is high E1→E2.
- Latency: 2 edges from accept to response. Back-to-back accepts give back-to-back `rvalid` pulses.
- Simultaneous requests with `prio`=0 and `lock1`=0: requester 0 is granted at E0 and requester 1 at E0+1 (still holding `req1`).
- Reset (async, `reset`=0) forces:
  - `prio`=0, `iss_v`=0, `rf_regwrite`=0
  - `rf_rs1`/`rf_rs2`/`rf_rd`=0, `rf_writedata`=0
  - `rvalid0`/`rvalid1`=0, all `rdata`=0
  - `gnt0`/`gnt1`=0 while reset is low
- Reset mid-operation: in-flight issue and response are discarded. A write whose commit edge has not yet occurred is not performed, because `rf_regwrite` drops asynchronously. No `rvalid` is produced for dropped requests.
- First accept is possible on the first rising edge after `reset` deasserts.

## Test plan
- Reset: drive `reset`=0 mid-write with `iss_v`=1 → `rf_regwrite`=0 immediately, no `rvalid`, all outputs 0; after release, `prio`=0.
- Single write then read: req0 writes x5=0xDEADBEEF_00000001 at E0, then reads rs1=5 at E1 → `rf_regwrite` high E0→E1; `rvalid0` at E1 (`rdata`=0); `rvalid0` at E2 with `rdata1_0`=0xDEADBEEF_00000001.
- x0 write: req1 writes x0=0xFFFF… → `rf_regwrite` stays 0, `rvalid1` pulses, later read of x0 returns 0.
- Contention round-robin: `req0`/`req1` both held for 4 cycles, `lock1`=0 → grants 0,1,0,1; `rvalid` pulses alternate two cycles later.
- Lock: both held, `lock1`=1 for 3 cycles, then `lock1`=0 → grants 1,1,1,0; `gnt` never both high.
- Back-to-back throughput: req0 issues 8 consecutive reads of x1..x8 preloaded with i*0x11 → 8 consecutive `rvalid0` cycles with matching data in order.
